// File: rtl/qam_pll_ctrl_pkg.sv
// Shared types, width defaults and helpers for the QAM carrier-recovery PLL controller.
package qam_pll_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAcquire = 2'd1,
    StSettle  = 2'd2,
    StLocked  = 2'd3
  } pll_state_t;

  localparam int unsigned DefErrW  = 16;
  localparam int unsigned DefGainW = 18;

  // Magnitude of a sign-extended w-bit value; the most negative code clamps to 2^(w-1)-1.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int unsigned w);
    logic [31:0] mag;
    logic [31:0] lim;
    lim = (32'd1 << (w - 1)) - 32'd1;
    mag = x[31] ? 32'(-x) : 32'(x);
    return (mag > lim) ? lim : mag;
  endfunction

endpackage

// File: rtl/qam_pll_loop_ctrl_if.sv
// Host/PLL-facing signal bundle of the loop controller; master is the controller side.
interface qam_pll_loop_ctrl_if #(
  parameter int unsigned ERR_W  = 16,
  parameter int unsigned GAIN_W = 18
);
  logic                     clk_enable;
  logic                     start;
  logic                     stop;
  logic [GAIN_W-1:0]        kp_acq;
  logic [GAIN_W-1:0]        ki_acq;
  logic [GAIN_W-1:0]        kp_trk;
  logic [GAIN_W-1:0]        ki_trk;
  logic [ERR_W-2:0]         lock_thresh;
  logic signed [ERR_W-1:0]  phase_err;
  logic                     pe_valid;
  logic                     sample_strobe;
  logic [GAIN_W-1:0]        kp;
  logic [GAIN_W-1:0]        ki;
  logic                     loop_enable;
  logic                     loop_flush;
  logic                     locked;
  logic                     acq_timeout;
  logic [1:0]               state;

  modport master (
    input  clk_enable, start, stop, kp_acq, ki_acq, kp_trk, ki_trk, lock_thresh,
           phase_err, pe_valid,
    output sample_strobe, kp, ki, loop_enable, loop_flush, locked, acq_timeout, state
  );

  modport slave (
    output clk_enable, start, stop, kp_acq, ki_acq, kp_trk, ki_trk, lock_thresh,
           phase_err, pe_valid,
    input  sample_strobe, kp, ki, loop_enable, loop_flush, locked, acq_timeout, state
  );
endinterface

// File: rtl/qam_pll_lock_detect.sv
// Lock detector: saturating |phase_err| threshold test and in-run / out-run counters.
module qam_pll_lock_detect
  import qam_pll_ctrl_pkg::*;
#(
  parameter int unsigned ERR_W      = DefErrW,
  parameter int unsigned LOCK_CNT   = 64,
  parameter int unsigned UNLOCK_CNT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample,
  input  logic                    clear,
  input  logic signed [ERR_W-1:0] phase_err,
  input  logic [ERR_W-2:0]        lock_thresh,
  output logic                    in_run_done,
  output logic                    out_run_done
);
  localparam int unsigned InW  = $clog2(LOCK_CNT + 1);
  localparam int unsigned OutW = $clog2(UNLOCK_CNT + 1);

  logic [InW-1:0]  in_cnt_q, in_cnt_d;
  logic [OutW-1:0] out_cnt_q, out_cnt_d;
  logic [31:0]     abs_val;
  logic            in_thr;

  assign abs_val = sat_abs(32'(phase_err), ERR_W);
  assign in_thr  = abs_val < 32'(lock_thresh);

  // Done fires on the sample that completes the run, so the FSM can act the same cycle.
  assign in_run_done  = sample && in_thr && (32'(in_cnt_q) >= LOCK_CNT - 1);
  assign out_run_done = sample && !in_thr && (32'(out_cnt_q) >= UNLOCK_CNT - 1);

  always_comb begin
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (clear) begin
      in_cnt_d  = '0;
      out_cnt_d = '0;
    end else if (sample) begin
      if (in_thr) begin
        out_cnt_d = '0;
        if (in_cnt_q != InW'(LOCK_CNT)) in_cnt_d = in_cnt_q + 1'b1;
      end else begin
        in_cnt_d = '0;
        if (out_cnt_q != OutW'(UNLOCK_CNT)) out_cnt_d = out_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: rtl/qam_pll_loop_ctrl.sv
// QAM PLL acquisition/tracking controller: sample-strobe divider, gain gear-shift FSM, lock flags.
module qam_pll_loop_ctrl
  import qam_pll_ctrl_pkg::*;
#(
  parameter int unsigned OVERCLOCK_FACTOR = 5,
  parameter int unsigned ERR_W            = DefErrW,
  parameter int unsigned GAIN_W           = DefGainW,
  parameter int unsigned LOCK_CNT         = 64,
  parameter int unsigned UNLOCK_CNT       = 16,
  parameter int unsigned ACQ_TIMEOUT      = 4096
) (
  input logic               clk,
  input logic               reset,
  qam_pll_loop_ctrl_if.master bus
);
  localparam int unsigned OcW  = $clog2(OVERCLOCK_FACTOR + 1);
  localparam int unsigned AcqW = $clog2(ACQ_TIMEOUT + 1);

  logic [OcW-1:0]    oc_cnt_q, oc_cnt_d;
  logic              strobe_q, strobe_d;
  pll_state_t        state_q, state_d;
  logic [AcqW-1:0]   acq_cnt_q, acq_cnt_d;
  logic              flush_q, flush_d;
  logic              timeout_q, timeout_d;
  logic              locked_q, locked_d;
  logic              loop_en_q, loop_en_d;
  logic [GAIN_W-1:0] kp_q, kp_d, ki_q, ki_d;
  logic              sample, timeout_evt, det_clear;
  logic              in_run_done, out_run_done;

  assign sample = bus.clk_enable && bus.pe_valid && (state_q != StIdle);

  qam_pll_lock_detect #(
    .ERR_W      (ERR_W),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) u_lock_detect (
    .clk          (clk),
    .reset        (reset),
    .sample       (sample),
    .clear        (det_clear),
    .phase_err    (bus.phase_err),
    .lock_thresh  (bus.lock_thresh),
    .in_run_done  (in_run_done),
    .out_run_done (out_run_done)
  );

  always_comb begin
    oc_cnt_d = oc_cnt_q;
    strobe_d = bus.clk_enable && (oc_cnt_q == OcW'(1));
    if (bus.clk_enable) begin
      oc_cnt_d = (oc_cnt_q == OcW'(OVERCLOCK_FACTOR)) ? OcW'(1) : oc_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    acq_cnt_d   = acq_cnt_q;
    flush_d     = 1'b0;
    timeout_d   = timeout_q;
    timeout_evt = 1'b0;
    if (bus.start) timeout_d = 1'b0;
    if (bus.stop) begin
      state_d = StIdle;
    end else if (bus.clk_enable) begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) state_d = StAcquire;
        end
        StAcquire: begin
          if (in_run_done) begin
            state_d = StSettle;
          end else if (sample) begin
            if (acq_cnt_q == AcqW'(ACQ_TIMEOUT - 1)) begin
              timeout_evt = 1'b1;
              timeout_d   = 1'b1;
              acq_cnt_d   = '0;
            end else begin
              acq_cnt_d = acq_cnt_q + 1'b1;
            end
          end
        end
        StSettle: begin
          if (in_run_done)       state_d = StLocked;
          else if (out_run_done) state_d = StAcquire;
        end
        StLocked: begin
          if (out_run_done) state_d = StAcquire;
        end
        default: state_d = StIdle;
      endcase
    end
    if (state_d != state_q) acq_cnt_d = '0;
    // Flush accompanies every ACQUIRE entry as well as each timeout restart.
    if ((state_d == StAcquire && state_q != StAcquire) || timeout_evt) flush_d = 1'b1;
    det_clear = (state_d != state_q) || timeout_evt;

    loop_en_d = (state_d != StIdle);
    locked_d  = (state_d == StLocked);
    unique case (state_d)
      StIdle:    begin kp_d = '0;          ki_d = '0;          end
      StAcquire: begin kp_d = bus.kp_acq;  ki_d = bus.ki_acq;  end
      default:   begin kp_d = bus.kp_trk;  ki_d = bus.ki_trk;  end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      oc_cnt_q  <= OcW'(1);
      strobe_q  <= 1'b0;
      state_q   <= StIdle;
      acq_cnt_q <= '0;
      flush_q   <= 1'b0;
      timeout_q <= 1'b0;
      locked_q  <= 1'b0;
      loop_en_q <= 1'b0;
      kp_q      <= '0;
      ki_q      <= '0;
    end else begin
      oc_cnt_q  <= oc_cnt_d;
      strobe_q  <= strobe_d;
      state_q   <= state_d;
      acq_cnt_q <= acq_cnt_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_d;
      locked_q  <= locked_d;
      loop_en_q <= loop_en_d;
      kp_q      <= kp_d;
      ki_q      <= ki_d;
    end
  end

  assign bus.sample_strobe = strobe_q;
  assign bus.kp            = kp_q;
  assign bus.ki            = ki_q;
  assign bus.loop_enable   = loop_en_q;
  assign bus.loop_flush    = flush_q;
  assign bus.locked        = locked_q;
  assign bus.acq_timeout   = timeout_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_qam_pll_loop_ctrl.sv
// Directed-vector bench for qam_pll_loop_ctrl with hand-computed expectations.
module tb_qam_pll_loop_ctrl;
  localparam int unsigned ErrW  = 16;
  localparam int unsigned GainW = 18;
  localparam logic [GainW-1:0] KpAcq = 18'd100;
  localparam logic [GainW-1:0] KiAcq = 18'd10;
  localparam logic [GainW-1:0] KpTrk = 18'd50;
  localparam logic [GainW-1:0] KiTrk = 18'd5;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  qam_pll_loop_ctrl_if #(.ERR_W(ErrW), .GAIN_W(GainW)) bus ();

  qam_pll_loop_ctrl #(
    .OVERCLOCK_FACTOR (5),
    .ERR_W            (ErrW),
    .GAIN_W           (GainW),
    .LOCK_CNT         (64),
    .UNLOCK_CNT       (16),
    .ACQ_TIMEOUT      (4096)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic signed [ErrW-1:0] err, input int n);
    bus.pe_valid  = 1'b1;
    bus.phase_err = err;
    repeat (n) tick();
    bus.pe_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.clk_enable = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.pe_valid = 1'b0;
    bus.phase_err = '0; bus.lock_thresh = 15'd20;
    bus.kp_acq = KpAcq; bus.ki_acq = KiAcq; bus.kp_trk = KpTrk; bus.ki_trk = KiTrk;
    repeat (2) tick();
    n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", bus.state); end
    n_checks++; if (bus.sample_strobe !== 1'b0) begin n_fail++; $display("FAIL rst_strobe: got %b want 0", bus.sample_strobe); end
    n_checks++; if (bus.loop_enable !== 1'b0) begin n_fail++; $display("FAIL rst_loop_en: got %b want 0", bus.loop_enable); end
    n_checks++; if (bus.kp !== '0 || bus.ki !== '0) begin n_fail++; $display("FAIL rst_gains: got kp=%0d ki=%0d want 0 0", bus.kp, bus.ki); end
    n_checks++; if (bus.loop_flush !== 1'b0 || bus.locked !== 1'b0 || bus.acq_timeout !== 1'b0) begin
      n_fail++; $display("FAIL rst_flags: got flush=%b locked=%b to=%b want 000", bus.loop_flush, bus.locked, bus.acq_timeout);
    end
    reset = 1'b0;
  endtask

  task automatic test_strobe();
    bus.clk_enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_checks++; if (bus.sample_strobe !== (k % 5 == 1)) begin
        n_fail++; $display("FAIL strobe_c%0d: got %b want %b", k, bus.sample_strobe, (k % 5 == 1));
      end
    end
    bus.clk_enable = 1'b0;
    repeat (3) begin
      tick();
      n_checks++; if (bus.sample_strobe !== 1'b0) begin n_fail++; $display("FAIL strobe_frozen: got %b want 0", bus.sample_strobe); end
    end
    bus.clk_enable = 1'b1;
    for (int k = 16; k <= 19; k++) begin
      tick();
      n_checks++; if (bus.sample_strobe !== (k == 19)) begin
        n_fail++; $display("FAIL strobe_delayed_c%0d: got %b want %b", k, bus.sample_strobe, (k == 19));
      end
    end
  endtask

  task automatic test_acquire_lock();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    n_checks++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL start_state: got %0d want 1", bus.state); end
    n_checks++; if (bus.loop_flush !== 1'b1 || bus.loop_enable !== 1'b1) begin
      n_fail++; $display("FAIL start_flush_en: got flush=%b en=%b want 1 1", bus.loop_flush, bus.loop_enable);
    end
    n_checks++; if (bus.kp !== KpAcq || bus.ki !== KiAcq) begin n_fail++; $display("FAIL acq_gains: got %0d %0d want 100 10", bus.kp, bus.ki); end
    tick();
    n_checks++; if (bus.loop_flush !== 1'b0) begin n_fail++; $display("FAIL flush_one_cycle: got %b want 0", bus.loop_flush); end
    feed(16'sd10, 32); feed(-16'sd10, 31);
    n_checks++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL acq_63: got %0d want 1", bus.state); end
    feed(-16'sd10, 1);
    n_checks++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL settle_64: got %0d want 2", bus.state); end
    n_checks++; if (bus.kp !== KpTrk || bus.ki !== KiTrk || bus.locked !== 1'b0) begin
      n_fail++; $display("FAIL settle_out: got kp=%0d ki=%0d locked=%b want 50 5 0", bus.kp, bus.ki, bus.locked);
    end
    feed(-16'sd10, 32); feed(16'sd10, 31);
    n_checks++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL settle_127: got %0d want 2", bus.state); end
    feed(16'sd10, 1);
    n_checks++; if (bus.state !== 2'd3 || bus.locked !== 1'b1) begin
      n_fail++; $display("FAIL locked_128: got state=%0d locked=%b want 3 1", bus.state, bus.locked);
    end
  endtask

  task automatic test_loss_of_lock();
    feed(16'sd500, 15); feed(16'sd5, 1);
    n_checks++; if (bus.state !== 2'd3) begin n_fail++; $display("FAIL hold_after_15: got %0d want 3", bus.state); end
    feed(16'sd500, 15);
    n_checks++; if (bus.state !== 2'd3 || bus.locked !== 1'b1) begin
      n_fail++; $display("FAIL hold_15_again: got state=%0d locked=%b want 3 1", bus.state, bus.locked);
    end
    feed(16'sd500, 1);
    n_checks++; if (bus.state !== 2'd1 || bus.locked !== 1'b0) begin
      n_fail++; $display("FAIL unlock_16: got state=%0d locked=%b want 1 0", bus.state, bus.locked);
    end
    n_checks++; if (bus.kp !== KpAcq || bus.loop_flush !== 1'b1) begin
      n_fail++; $display("FAIL unlock_out: got kp=%0d flush=%b want 100 1", bus.kp, bus.loop_flush);
    end
    tick();
  endtask

  task automatic test_timeout();
    feed(16'sd1000, 4095);
    n_checks++; if (bus.acq_timeout !== 1'b0 || bus.loop_flush !== 1'b0) begin
      n_fail++; $display("FAIL to_early: got to=%b flush=%b want 0 0", bus.acq_timeout, bus.loop_flush);
    end
    feed(16'sd1000, 1);
    n_checks++; if (bus.acq_timeout !== 1'b1 || bus.loop_flush !== 1'b1 || bus.state !== 2'd1) begin
      n_fail++; $display("FAIL to_4096: got to=%b flush=%b state=%0d want 1 1 1", bus.acq_timeout, bus.loop_flush, bus.state);
    end
    tick();
    n_checks++; if (bus.acq_timeout !== 1'b1 || bus.loop_flush !== 1'b0) begin
      n_fail++; $display("FAIL to_sticky: got to=%b flush=%b want 1 0", bus.acq_timeout, bus.loop_flush);
    end
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    n_checks++; if (bus.acq_timeout !== 1'b0 || bus.state !== 2'd1 || bus.loop_flush !== 1'b0) begin
      n_fail++; $display("FAIL to_clear: got to=%b state=%0d flush=%b want 0 1 0", bus.acq_timeout, bus.state, bus.loop_flush);
    end
  endtask

  task automatic test_boundaries();
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    n_checks++; if (bus.state !== 2'd0 || bus.loop_enable !== 1'b0 || bus.kp !== '0) begin
      n_fail++; $display("FAIL stop_idle: got state=%0d en=%b kp=%0d want 0 0 0", bus.state, bus.loop_enable, bus.kp);
    end
    bus.start = 1'b1; bus.stop = 1'b1; tick(); bus.start = 1'b0; bus.stop = 1'b0;
    n_checks++; if (bus.state !== 2'd0 || bus.loop_flush !== 1'b0) begin
      n_fail++; $display("FAIL start_stop: got state=%0d flush=%b want 0 0", bus.state, bus.loop_flush);
    end
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.lock_thresh = 15'd32767;
    feed(-16'sd32768, 64);
    n_checks++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL neg_full_scale: got %0d want 1", bus.state); end
    bus.lock_thresh = 15'd20;
    feed(16'sd20, 64);
    n_checks++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL equal_thresh: got %0d want 1", bus.state); end
    feed(16'sd19, 64);
    n_checks++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL below_thresh: got %0d want 2", bus.state); end
  endtask

  task automatic test_reset_locked();
    feed(-16'sd19, 64);
    n_checks++; if (bus.state !== 2'd3) begin n_fail++; $display("FAIL relock: got %0d want 3", bus.state); end
    reset = 1'b1; bus.clk_enable = 1'b0; tick(); reset = 1'b0;
    n_checks++; if (bus.state !== 2'd0 || bus.locked !== 1'b0 || bus.loop_enable !== 1'b0) begin
      n_fail++; $display("FAIL rst_locked: got state=%0d locked=%b en=%b want 0 0 0", bus.state, bus.locked, bus.loop_enable);
    end
    n_checks++; if (bus.kp !== '0 || bus.ki !== '0 || bus.sample_strobe !== 1'b0) begin
      n_fail++; $display("FAIL rst_locked_out: got kp=%0d ki=%0d strobe=%b want 0 0 0", bus.kp, bus.ki, bus.sample_strobe);
    end
    bus.clk_enable = 1'b1; tick();
    n_checks++; if (bus.sample_strobe !== 1'b1) begin n_fail++; $display("FAIL first_strobe_after_rst: got %b want 1", bus.sample_strobe); end
  endtask

  initial begin
    test_reset();
    test_strobe();
    test_acquire_lock();
    test_loss_of_lock();
    test_timeout();
    test_boundaries();
    test_reset_locked();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/qam_pll_loop_ctrl.md
# qam_pll_loop_ctrl

Acquisition/tracking controller for the QAM carrier-recovery PLL. It generates the PLL sample strobe by dividing `clk_enable` by the overclocking factor. It gear-shifts the loop-filter gains (KP/KI) between acquisition and tracking sets, and gates the loop enable. It also runs lock/unlock detection on the returned phase error and sits between the host configuration registers and the PLL datapath.

## Interface
Parameters:
- `OVERCLOCK_FACTOR`, 5: `clk_enable` cycles per PLL sample (≥1).
- `ERR_W`, 16: signed phase-error width.
- `GAIN_W`, 18: unsigned gain width.
- `LOCK_CNT`, 64: consecutive in-threshold samples to advance lock state.
- `UNLOCK_CNT`, 16: consecutive out-of-threshold samples to drop lock.
- `ACQ_TIMEOUT`, 4096: samples allowed in ACQUIRE before flush.

Ports:
- `clk`, in, 1: clock. One clock domain.
- `reset`, in, 1: synchronous, active-high.
- `clk_enable`, in, 1: global advance qualifier.
- `start`, in, 1: pulse; leave IDLE.
- `stop`, in, 1: pulse; return to IDLE.
- `kp_acq`, `ki_acq`, in, GAIN_W: acquisition gains.
- `kp_trk`, `ki_trk`, in, GAIN_W: tracking gains.
- `lock_thresh`, in, ERR_W-1: unsigned phase-error lock threshold.
- `phase_err`, in, ERR_W: signed PLL phase error.
- `pe_valid`, in, 1: `phase_err` valid this cycle.
- `sample_strobe`, out, 1: PLL advance pulse.
- `kp`, `ki`, out, GAIN_W: active gains to the PLL.
- `loop_enable`, out, 1: PLL Enable.
- `loop_flush`, out, 1: one-cycle PLL reinitialise request.
- `locked`, out, 1: lock indication.
- `acq_timeout`, out, 1: sticky timeout flag, cleared by `start`.
- `state`, out, 2: current FSM state.

## Operation
- Overclock counter runs 1..OVERCLOCK_FACTOR and advances only when `clk_enable`=1. It wraps to 1 after OVERCLOCK_FACTOR.
- `sample_strobe` = `clk_enable` && counter==1, and is registered. With OVERCLOCK_FACTOR=1, the strobe equals the registered `clk_enable`.
- `clk_enable`=0 freezes the counter, FSM and all detector counters. `stop` and `reset` still act.
- FSM states: IDLE=0, ACQUIRE=1, SETTLE=2, LOCKED=3.
- **IDLE**
  - `loop_enable`=0, `kp`=`ki`=0.
  - `start` → ACQUIRE and pulse `loop_flush`.
- **ACQUIRE**
  - Outputs acquisition gains; `loop_enable`=1.
  - `LOCK_CNT` consecutive in-threshold samples → SETTLE.
  - After `ACQ_TIMEOUT` samples without reaching SETTLE: set `acq_timeout`, pulse `loop_flush`, clear counters, and stay in ACQUIRE.
- **SETTLE**
  - Outputs tracking gains.
  - `LOCK_CNT` consecutive in-threshold samples → LOCKED.
  - `UNLOCK_CNT` consecutive out-of-threshold samples → ACQUIRE.
- **LOCKED**
  - Tracking gains; `locked`=1.
  - `UNLOCK_CNT` consecutive out-of-threshold samples → ACQUIRE and drop `locked`.
- Lock detector:
  - A sample counts only when `pe_valid`=1 and the state is not IDLE.
  - In-threshold means |`phase_err`| < `lock_thresh` (strict).
  - |−2^(ERR_W−1)| saturates to 2^(ERR_W−1)−1.
  - An in-threshold sample clears the out-run counter; an out-of-threshold sample clears the in-run counter.
  - Both counters clear on every state change.
  - Counters saturate and never wrap.
- `stop` from any state → IDLE. `stop` beats a simultaneous `start`.
- `start` outside IDLE is ignored, except that it clears `acq_timeout`.
- Gain inputs are sampled live. Host changes them only in IDLE; a change outside IDLE takes effect on the next cycle.
- Reset values:
  - state IDLE, counter 1.
  - `sample_strobe`, `loop_enable`, `loop_flush`, `locked`, `acq_timeout` all 0.
  - `kp`=`ki`=0, all run counters 0.

## Timing
- All outputs are registered.
- A state transition is decided in the cycle of the qualifying `pe_valid`. The new state, gains, `loop_enable` and `locked` appear on the next cycle.
- `loop_flush` is high for exactly one cycle, coincident with the ACQUIRE entry or timeout cycle.
- Strobe period is OVERCLOCK_FACTOR enabled cycles. The first strobe is the first enabled cycle after reset release.
- `reset` mid-operation returns everything to reset values on the next edge, regardless of `clk_enable`.

## Structure
- Package `qam_pll_ctrl_pkg`:
  - `pll_state_t` enum (IDLE/ACQUIRE/SETTLE/LOCKED).
  - Default width constants.
  - Saturating-abs function.
- Sub-module `qam_pll_lock_detect`: abs, threshold compare, in-run/out-run counters. It outputs `in_run_done` and `out_run_done`.
- The top level holds the overclock divider, FSM and output registers.

## Test plan
- **Strobe divider:** reset, `clk_enable`=1 constant, OVERCLOCK_FACTOR=5 → strobe on cycles 1, 6, 11. Hold `clk_enable`=0 for 3 cycles mid-count → the next strobe is delayed by 3.
- **Acquire to lock:** `start`, `phase_err`=±10 with `lock_thresh`=20 on every strobe → SETTLE after 64 samples with `kp`=`kp_trk`; LOCKED and `locked`=1 after 128 samples.
- **Loss of lock:** while LOCKED, feed 15 samples of 500 then 1 sample of 5 → stays LOCKED. Then feed 16 samples of 500 → ACQUIRE, `locked`=0, `kp`=`kp_acq`.
- **Timeout:** `phase_err`=1000 constant, ACQ_TIMEOUT=4096 → `acq_timeout`=1 and a one-cycle `loop_flush` at sample 4096. A following `start` clears the flag.
- **Boundaries:**
  - `phase_err`=−32768 with `lock_thresh`=32767 → counts as out-of-threshold.
  - `phase_err`=20 with `lock_thresh`=20 → out-of-threshold.
  - `start` and `stop` in the same cycle in IDLE → stays IDLE.
  - `reset` asserted while LOCKED → all reset values next cycle.
